// File: rtl/rvv_uop_queue_pkg.sv
// Shared types and default sizing for the decode-to-dispatch uop queue.
// UOP_QUEUE_t is the record carried from decode, through the queue, to dispatch.
package rvv_uop_queue_pkg;

  localparam int UQ_DEPTH      = 16;
  localparam int UQ_NUM_DE_UOP = 4;
  localparam int UQ_NUM_DP_UOP = 2;

  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  vd;
    logic [2:0]  sew;
    logic        last_uop;
    logic [7:0]  tag;
  } UOP_QUEUE_t;

endpackage

// File: rtl/rvv_leading_ones_cnt.sv
// Counts the run of 1s starting at bit 0; stops at the first 0.
// Purely combinational.
module rvv_leading_ones_cnt #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & bits[i];
      if (run) cnt = cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rvv_uop_queue.sv
// Multi-write/multi-read circular uop FIFO between decode and dispatch; head visible one cycle after push.
// Decode may push only when a full NUM_DE_UOP group fits, judged on the registered count alone.
module rvv_uop_queue
  import rvv_uop_queue_pkg::*;
#(
  parameter int DEPTH      = UQ_DEPTH,
  parameter int NUM_DE_UOP = UQ_NUM_DE_UOP,
  parameter int NUM_DP_UOP = UQ_NUM_DP_UOP
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_DE_UOP-1:0]              uop_valid_de2uq,
  input  UOP_QUEUE_t [NUM_DE_UOP-1:0]        uop_de2uq,
  output logic                               uq_ready_de2uq,
  output logic [NUM_DP_UOP-1:0]              uop_valid_uq2dp,
  output UOP_QUEUE_t [NUM_DP_UOP-1:0]        uop_uq2dp,
  input  logic [NUM_DP_UOP-1:0]              uop_ready_dp2uq,
  input  logic                               trap_flush_rvv,
  output logic                               uq_empty,
  output logic                               uq_full
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PUW = $clog2(NUM_DE_UOP + 1);
  localparam int POW = $clog2(NUM_DP_UOP + 1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  UOP_QUEUE_t            mem [DEPTH];

  logic [PUW-1:0]        push_run;
  logic [PUW-1:0]        push_num;
  logic [POW-1:0]        pop_num;
  logic [NUM_DP_UOP-1:0] pop_req;

  // Ready looks only at count so dispatch accepts never feed back into decode in the same cycle.
  assign uq_ready_de2uq = (CW'(DEPTH) - count) >= CW'(NUM_DE_UOP);
  assign uq_empty       = (count == '0);
  assign uq_full        = (count == CW'(DEPTH));

  rvv_leading_ones_cnt #(.W(NUM_DE_UOP), .CW(PUW)) u_push_cnt (
    .bits (uop_valid_de2uq),
    .cnt  (push_run)
  );

  assign push_num = uq_ready_de2uq ? push_run : '0;

  always_comb begin
    uop_valid_uq2dp = '0;
    uop_uq2dp       = '0;
    for (int j = 0; j < NUM_DP_UOP; j++) begin
      uop_valid_uq2dp[j] = (count > CW'(j));
      uop_uq2dp[j]       = mem[rd_ptr + PW'(j)];
    end
  end

  assign pop_req = uop_valid_uq2dp & uop_ready_dp2uq;

  rvv_leading_ones_cnt #(.W(NUM_DP_UOP), .CW(POW)) u_pop_cnt (
    .bits (pop_req),
    .cnt  (pop_num)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (trap_flush_rvv) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_num);
      rd_ptr <= rd_ptr + PW'(pop_num);
      count  <= count + CW'(push_num) - CW'(pop_num);
    end
  end

  // Storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk) begin
    if (!trap_flush_rvv) begin
      for (int i = 0; i < NUM_DE_UOP; i++) begin
        if (PUW'(i) < push_num) mem[wr_ptr + PW'(i)] <= uop_de2uq[i];
      end
    end
  end

`ifdef ASSERT_ON
  always @(posedge clk) begin
    if (!rst) begin
      a_count_bound : assert (count <= CW'(DEPTH))
        else $error("uop queue count above depth");
      a_push_when_full : assert (uq_ready_de2uq || (uop_valid_de2uq == '0))
        else $error("decoder pushed while queue not ready");
      a_valid_contig : assert ((uop_valid_de2uq & (uop_valid_de2uq + NUM_DE_UOP'(1))) == '0)
        else $error("non-contiguous decoder valid");
    end
  end
`endif

endmodule

// File: tb/tb_rvv_uop_queue.sv
// Directed bench for rvv_uop_queue: table of per-cycle vectors plus hand sequences
// for protocol-violation pushes, flush-era data and asynchronous reset.
module tb_rvv_uop_queue;
  import rvv_uop_queue_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       vin;
  UOP_QUEUE_t [3:0] din;
  logic             rdy_de;
  logic [1:0]       vout;
  UOP_QUEUE_t [1:0] dout;
  logic [1:0]       rdy_dp;
  logic             flush;
  logic             empty;
  logic             full;

  int checks   = 0;
  int errors   = 0;
  int next_tag = 0;

  always #5 clk = ~clk;

  rvv_uop_queue dut (
    .clk             (clk),
    .rst             (rst),
    .uop_valid_de2uq (vin),
    .uop_de2uq       (din),
    .uq_ready_de2uq  (rdy_de),
    .uop_valid_uq2dp (vout),
    .uop_uq2dp       (dout),
    .uop_ready_dp2uq (rdy_dp),
    .trap_flush_rvv  (flush),
    .uq_empty        (empty),
    .uq_full         (full)
  );

  typedef struct {
    logic [3:0] v;
    logic [1:0] r;
    logic       f;
    int         npush;
    int         cnt;
    logic [1:0] vld;
    logic       rdy;
    logic       emp;
    logic       ful;
    int         h0;
    int         h1;
  } vec_t;

  vec_t tbl[$];

  function automatic UOP_QUEUE_t mk(input int t);
    UOP_QUEUE_t u;
    u.insn     = 32'hC0DE_0000 | 32'(t);
    u.vd       = 5'(t);
    u.sew      = 3'(t >> 2);
    u.last_uop = t[0];
    u.tag      = 8'(t);
    return u;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [1:0] r, input logic f, input int npush,
                     input int cnt, input logic [1:0] vld, input logic rdy, input logic emp,
                     input logic ful, input int h0, input int h1);
    vec_t e;
    e.v = v; e.r = r; e.f = f; e.npush = npush; e.cnt = cnt; e.vld = vld;
    e.rdy = rdy; e.emp = emp; e.ful = ful; e.h0 = h0; e.h1 = h1;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic [3:0] v, input logic [1:0] r, input logic f);
    vin    = v;
    rdy_dp = r;
    flush  = f;
    for (int i = 0; i < 4; i++) din[i] = mk(next_tag + i);
  endtask

  // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
  task automatic step(input logic [3:0] v, input logic [1:0] r, input logic f, input int npush);
    drive(v, r, f);
    @(posedge clk);
    #1;
    next_tag += npush;
    vin    = '0;
    rdy_dp = '0;
    flush  = 1'b0;
  endtask

  task automatic chk_state(input string p, input int cnt, input logic [1:0] vld,
                           input logic rdy, input logic emp, input logic ful);
    chk({p, " count"}, 64'(dut.count), 64'(cnt));
    chk({p, " valid"}, 64'(vout), 64'(vld));
    chk({p, " ready"}, 64'(rdy_de), 64'(rdy));
    chk({p, " empty"}, 64'(empty), 64'(emp));
    chk({p, " full"},  64'(full), 64'(ful));
  endtask

  initial begin
    int b;
    int lone;

    vin = '0; rdy_dp = '0; flush = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = mk(0);

    //   v        r      f    np cnt vld    rdy   emp   ful   h0  h1
    add(4'b1111, 2'b00, 1'b0, 4,  4, 2'b11, 1'b1, 1'b0, 1'b0,  0,  1);
    add(4'b1111, 2'b00, 1'b0, 4,  8, 2'b11, 1'b1, 1'b0, 1'b0,  0,  1);
    add(4'b0111, 2'b00, 1'b0, 3, 11, 2'b11, 1'b1, 1'b0, 1'b0,  0,  1);
    add(4'b0011, 2'b00, 1'b0, 2, 13, 2'b11, 1'b0, 1'b0, 1'b0,  0,  1);
    add(4'b0000, 2'b11, 1'b0, 0, 11, 2'b11, 1'b1, 1'b0, 1'b0,  2,  3);
    add(4'b1111, 2'b01, 1'b0, 4, 14, 2'b11, 1'b0, 1'b0, 1'b0,  3,  4);
    add(4'b0000, 2'b11, 1'b0, 0, 12, 2'b11, 1'b1, 1'b0, 1'b0,  5,  6);
    add(4'b1111, 2'b10, 1'b0, 4, 16, 2'b11, 1'b0, 1'b0, 1'b1,  5,  6);
    add(4'b0000, 2'b11, 1'b0, 0, 14, 2'b11, 1'b0, 1'b0, 1'b0,  7,  8);
    add(4'b0000, 2'b11, 1'b0, 0, 12, 2'b11, 1'b1, 1'b0, 1'b0,  9, 10);
    add(4'b1111, 2'b11, 1'b0, 4, 14, 2'b11, 1'b0, 1'b0, 1'b0, 11, 12);
    add(4'b0000, 2'b11, 1'b0, 0, 12, 2'b11, 1'b1, 1'b0, 1'b0, 13, 14);
    add(4'b0000, 2'b11, 1'b0, 0, 10, 2'b11, 1'b1, 1'b0, 1'b0, 15, 16);
    add(4'b0000, 2'b11, 1'b0, 0,  8, 2'b11, 1'b1, 1'b0, 1'b0, 17, 18);
    add(4'b0000, 2'b11, 1'b0, 0,  6, 2'b11, 1'b1, 1'b0, 1'b0, 19, 20);
    add(4'b0000, 2'b11, 1'b0, 0,  4, 2'b11, 1'b1, 1'b0, 1'b0, 21, 22);
    add(4'b0000, 2'b11, 1'b0, 0,  2, 2'b11, 1'b1, 1'b0, 1'b0, 23, 24);
    add(4'b0000, 2'b11, 1'b0, 0,  0, 2'b00, 1'b1, 1'b1, 1'b0,  0,  0);
    add(4'b0001, 2'b00, 1'b0, 1,  1, 2'b01, 1'b1, 1'b0, 1'b0, 25,  0);
    add(4'b0000, 2'b11, 1'b0, 0,  0, 2'b00, 1'b1, 1'b1, 1'b0,  0,  0);
    add(4'b0011, 2'b00, 1'b0, 2,  2, 2'b11, 1'b1, 1'b0, 1'b0, 26, 27);
    add(4'b0000, 2'b10, 1'b0, 0,  2, 2'b11, 1'b1, 1'b0, 1'b0, 26, 27);
    add(4'b0000, 2'b11, 1'b0, 0,  0, 2'b00, 1'b1, 1'b1, 1'b0,  0,  0);
    add(4'b0011, 2'b11, 1'b0, 2,  2, 2'b11, 1'b1, 1'b0, 1'b0, 28, 29);
    add(4'b0000, 2'b11, 1'b0, 0,  0, 2'b00, 1'b1, 1'b1, 1'b0,  0,  0);
    add(4'b1111, 2'b00, 1'b0, 4,  4, 2'b11, 1'b1, 1'b0, 1'b0, 30, 31);
    add(4'b1111, 2'b00, 1'b0, 4,  8, 2'b11, 1'b1, 1'b0, 1'b0, 30, 31);
    add(4'b1111, 2'b11, 1'b1, 4,  0, 2'b00, 1'b1, 1'b1, 1'b0,  0,  0);
    add(4'b0001, 2'b00, 1'b0, 1,  1, 2'b01, 1'b1, 1'b0, 1'b0, 42,  0);
    add(4'b0000, 2'b01, 1'b0, 0,  0, 2'b00, 1'b1, 1'b1, 1'b0,  0,  0);

    #3;
    chk_state("in_reset", 0, 2'b00, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_state("after_reset", 0, 2'b00, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].v, tbl[k].r, tbl[k].f, tbl[k].npush);
      chk_state($sformatf("row%0d", k), tbl[k].cnt, tbl[k].vld, tbl[k].rdy, tbl[k].emp, tbl[k].ful);
      if (tbl[k].vld[0]) chk($sformatf("row%0d head0", k), 64'(dout[0]), 64'(mk(tbl[k].h0)));
      if (tbl[k].vld[1]) chk($sformatf("row%0d head1", k), 64'(dout[1]), 64'(mk(tbl[k].h1)));
    end

`ifndef ASSERT_ON
    // Decoder protocol violations: push while not ready, and a non-contiguous valid mask.
    b = next_tag;
    step(4'b1111, 2'b00, 1'b0, 4);
    step(4'b1111, 2'b00, 1'b0, 4);
    step(4'b1111, 2'b00, 1'b0, 4);
    step(4'b0001, 2'b00, 1'b0, 1);
    chk_state("fill13", 13, 2'b11, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 2'b00, 1'b0, 4);
    chk_state("push_not_ready", 13, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("push_not_ready head0", 64'(dout[0]), 64'(mk(b)));
    step(4'b0000, 2'b11, 1'b0, 0);
    chk_state("pop_to_11", 11, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("pop_to_11 head0", 64'(dout[0]), 64'(mk(b + 2)));
    lone = next_tag;
    step(4'b0101, 2'b00, 1'b0, 4);
    chk_state("noncontig", 12, 2'b11, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0000, 2'b11, 1'b0, 0);
    chk_state("drain_to_2", 2, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("drain_to_2 head0", 64'(dout[0]), 64'(mk(b + 12)));
    chk("drain_to_2 head1", 64'(dout[1]), 64'(mk(lone)));
    step(4'b0000, 2'b11, 1'b0, 0);
    chk_state("drained", 0, 2'b00, 1'b1, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-stream with pushes and pops in flight.
    b = next_tag;
    step(4'b1111, 2'b00, 1'b0, 4);
    step(4'b0111, 2'b00, 1'b0, 3);
    chk_state("pre_rst", 7, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("pre_rst head0", 64'(dout[0]), 64'(mk(b)));
    drive(4'b1111, 2'b11, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 2'b00, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_state("rst_held", 0, 2'b00, 1'b1, 1'b1, 1'b0);
    rst    = 1'b0;
    vin    = '0;
    rdy_dp = '0;
    next_tag += 8;
    b = next_tag;
    step(4'b0011, 2'b00, 1'b0, 2);
    chk_state("post_rst", 2, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("post_rst head0", 64'(dout[0]), 64'(mk(b)));
    chk("post_rst head1", 64'(dout[1]), 64'(mk(b + 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
